// File: rtl/mmio_uart_rx_if.sv
// MMIO bus bundle for the UART receiver: one-cycle access strobe, byte enables,
// address/data, and the registered read-data return path.
interface mmio_uart_rx_if;
  logic        mmio_oe;
  logic [3:0]  mmio_we;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;

  modport master (output mmio_oe, mmio_we, mmio_addr, mmio_wdata, input mmio_rdata);
  modport slave  (input mmio_oe, mmio_we, mmio_addr, mmio_wdata, output mmio_rdata);
endinterface

// File: rtl/mmio_uart_rx.sv
// UART 8N1 receiver with mid-bit sampling, a small byte FIFO and an MMIO
// register pair (RXDATA pops, STATUS carries sticky W1C error flags).
module mmio_uart_rx #(
  parameter int          DIVISOR         = 868,
  parameter int          FIFO_DEPTH_LOG2 = 4,
  parameter logic [31:0] BASE            = 32'hf0000104
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rxd,
  mmio_uart_rx_if.slave  bus,
  output logic           rx_irq
);
  localparam int          CW   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int          L    = FIFO_DEPTH_LOG2;
  localparam logic [CW-1:0] HALF = CW'(DIVISOR/2 - 1);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);
  localparam logic [31:0] STAT = BASE + 32'd4;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          s1, s2, rs;
  logic [1:0]    warm;
  logic          armed;
  logic          push, fe_set;

  logic [7:0]    mem [2**L];
  logic [L:0]    wp, rp, wp_n, rp_n;
  logic          empty, full, pop, push_ok, ovr_set;
  logic          overrun, frame_err;
  logic          rd, wr, clr;

  assign rs = s2;

  // A start bit is only accepted once the synchronizer holds real line samples
  // and the line has been seen idle, so a low line at reset release is ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      warm  <= 2'b00;
      armed <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      s1    <= rxd;
      s2    <= s1;
      warm  <= {warm[0], 1'b1};
      if (warm[1] && rs) armed <= 1'b1;
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    push    = 1'b0;
    fe_set  = 1'b0;
    case (state)
      IDLE: if (!rs && armed) begin
        state_n = START;
        cnt_n   = '0;
      end
      START: if (cnt == HALF) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rs ? IDLE : DATA;
      end else cnt_n = cnt + 1'b1;
      DATA: if (cnt == LAST) begin
        cnt_n          = '0;
        shift_n[idx]   = rs;
        idx_n          = idx + 3'd1;
        if (idx == 3'd7) state_n = STOP;
      end else cnt_n = cnt + 1'b1;
      STOP: if (cnt == LAST) begin
        cnt_n = '0;
        if (rs) begin
          push    = 1'b1;
          state_n = IDLE;
        end else begin
          fe_set  = 1'b1;
          state_n = BREAK;
        end
      end else cnt_n = cnt + 1'b1;
      BREAK: if (rs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign rd      = bus.mmio_oe && (bus.mmio_we == 4'b0);
  assign wr      = bus.mmio_oe && (bus.mmio_we != 4'b0);
  assign clr     = wr && (bus.mmio_addr == STAT) && bus.mmio_we[0];
  assign empty   = (wp == rp);
  assign full    = (wp[L] != rp[L]) && (wp[L-1:0] == rp[L-1:0]);
  assign pop     = rd && (bus.mmio_addr == BASE) && !empty;
  // A full FIFO still accepts the byte when the same cycle pops the head.
  assign push_ok = push && (!full || pop);
  assign ovr_set = push && full && !pop;
  assign wp_n    = wp + (L+1)'(push_ok);
  assign rp_n    = rp + (L+1)'(pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp[L-1:0]] <= shift;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp             <= '0;
      rp             <= '0;
      overrun        <= 1'b0;
      frame_err      <= 1'b0;
      rx_irq         <= 1'b0;
      bus.mmio_rdata <= '0;
    end else begin
      wp        <= wp_n;
      rp        <= rp_n;
      overrun   <= ovr_set | (overrun & ~(clr & bus.mmio_wdata[1]));
      frame_err <= fe_set | (frame_err & ~(clr & bus.mmio_wdata[2]));
      rx_irq    <= (wp_n != rp_n);
      if (rd && bus.mmio_addr == BASE)
        bus.mmio_rdata <= empty ? 32'h8000_0000 : {24'b0, mem[rp[L-1:0]]};
      else if (rd && bus.mmio_addr == STAT)
        bus.mmio_rdata <= {29'b0, frame_err, overrun, !empty};
      else
        bus.mmio_rdata <= '0;
    end
  end
endmodule

// File: tb/tb_mmio_uart_rx.sv
// Bench for mmio_uart_rx: directed frames and a register-access table, then
// random frames/accesses checked against a queue-based model of the receiver.
module tb_mmio_uart_rx;
  localparam int          DIV  = 16;
  localparam int          DEP  = 4;
  localparam logic [31:0] BASE = 32'hf0000104;
  localparam logic [31:0] STAT = BASE + 32'd4;

  logic clk = 1'b0, rst = 1'b0, rxd = 1'b1, rx_irq;
  mmio_uart_rx_if bus ();

  mmio_uart_rx #(.DIVISOR(DIV), .FIFO_DEPTH_LOG2(2), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .bus(bus), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  logic [7:0] q[$];
  bit         m_ovr, m_fe;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_ovr = 0;
    m_fe  = 0;
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (q.size() < DEP) q.push_back(b);
    else m_ovr = 1;
  endfunction

  // Expected read data for one access; applies the access's side effects.
  function automatic logic [31:0] model_op(input logic [31:0] a, input logic [3:0] w,
                                           input logic [31:0] d);
    logic [31:0] r;
    r = 32'h0;
    if (w == 4'h0) begin
      if (a == BASE) r = (q.size() != 0) ? {24'h0, q.pop_front()} : 32'h8000_0000;
      else if (a == STAT) r = {29'h0, m_fe, m_ovr, q.size() != 0};
    end else if (a == STAT && w[0]) begin
      if (d[1]) m_ovr = 0;
      if (d[2]) m_fe  = 0;
    end
    return r;
  endfunction

  task automatic mmio_op(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                         output logic [31:0] r);
    @(negedge clk);
    bus.mmio_oe = 1'b1; bus.mmio_we = w; bus.mmio_addr = a; bus.mmio_wdata = d;
    @(negedge clk);
    bus.mmio_oe = 1'b0; bus.mmio_we = 4'h0; bus.mmio_addr = 32'h0; bus.mmio_wdata = 32'h0;
    r = bus.mmio_rdata;
    @(negedge clk);
    chk("rdata_one_cycle", bus.mmio_rdata, 32'h0);
  endtask

  // One access checked against the model and, when use_k, a fixed expectation.
  task automatic do_op(input string name, input logic [31:0] a, input logic [3:0] w,
                       input logic [31:0] d, input bit use_k, input logic [31:0] k);
    logic [31:0] r, e;
    e = model_op(a, w, d);
    mmio_op(a, w, d, r);
    chk(name, r, e);
    if (use_k) chk({name, "_const"}, r, k);
    chk({name, "_irq"}, {31'h0, rx_irq}, {31'h0, q.size() != 0});
  endtask

  // One 8N1 frame. The stop level is held for 16+extra bit-cycles; with rd_at_push
  // a RXDATA read is placed on the cycle the receiver samples the stop bit.
  task automatic send(input logic [7:0] b, input bit stop_ok, input int extra,
                      input bit rd_at_push, output logic [31:0] r);
    r = 32'h0;
    @(negedge clk); rxd = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stop_ok;
    if (rd_at_push) begin
      repeat (DIV - 6) @(negedge clk);
      bus.mmio_oe = 1'b1; bus.mmio_we = 4'h0; bus.mmio_addr = BASE;
      @(negedge clk);
      bus.mmio_oe = 1'b0; bus.mmio_addr = 32'h0;
      r = bus.mmio_rdata;
      repeat (5) @(negedge clk);
    end else begin
      repeat (DIV + extra) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_m(input logic [7:0] b, input bit stop_ok);
    logic [31:0] r;
    send(b, stop_ok, 0, 1'b0, r);
    if (stop_ok) model_push(b);
    else m_fe = 1;
  endtask

  initial begin
    logic [31:0] r, e;
    tbl[0]  = '{"t_stat_ovr",   STAT,              4'h0, 32'h0,  32'h3};
    tbl[1]  = '{"t_rd_01",      BASE,              4'h0, 32'h0,  32'h01};
    tbl[2]  = '{"t_rd_other",   BASE + 32'd8,      4'h0, 32'h0,  32'h0};
    tbl[3]  = '{"t_wr_base",    BASE,              4'hF, 32'hFF, 32'h0};
    tbl[4]  = '{"t_rd_02",      BASE,              4'h0, 32'h0,  32'h02};
    tbl[5]  = '{"t_rd_03",      BASE,              4'h0, 32'h0,  32'h03};
    tbl[6]  = '{"t_rd_04",      BASE,              4'h0, 32'h0,  32'h04};
    tbl[7]  = '{"t_rd_empty",   BASE,              4'h0, 32'h0,  32'h8000_0000};
    tbl[8]  = '{"t_wr_noclr",   STAT,              4'h2, 32'h6,  32'h0};
    tbl[9]  = '{"t_wr_clr_ovr", STAT,              4'h1, 32'h2,  32'h0};
    tbl[10] = '{"t_stat_clr",   STAT,              4'h0, 32'h0,  32'h0};

    bus.mmio_oe = 1'b0; bus.mmio_we = 4'h0; bus.mmio_addr = 32'h0; bus.mmio_wdata = 32'h0;
    model_reset();
    repeat (4) @(negedge clk);
    chk("rst_rdata", bus.mmio_rdata, 32'h0);
    chk("rst_irq", {31'h0, rx_irq}, 32'h0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    do_op("rst_status", STAT, 4'h0, 32'h0, 1'b1, 32'h0);

    // single byte, pop, then empty read
    send_m(8'h55, 1'b1);
    chk("irq_after_rx", {31'h0, rx_irq}, 32'h1);
    do_op("rd_55", BASE, 4'h0, 32'h0, 1'b1, 32'h55);
    do_op("rd_empty", BASE, 4'h0, 32'h0, 1'b1, 32'h8000_0000);

    // short low glitch must not start a frame
    @(negedge clk); rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    do_op("glitch_status", STAT, 4'h0, 32'h0, 1'b1, 32'h0);

    // five bytes into a four-deep FIFO, then the register table
    for (int i = 1; i <= 5; i++) send_m(8'(i), 1'b1);
    foreach (tbl[i]) do_op(tbl[i].name, tbl[i].addr, tbl[i].we, tbl[i].wdata, 1'b1, tbl[i].exp);

    // framing error, long break, then a good byte
    send(8'hA3, 1'b0, 40 * DIV, 1'b0, r);
    m_fe = 1;
    send_m(8'h7E, 1'b1);
    do_op("fe_status", STAT, 4'h0, 32'h0, 1'b1, 32'h5);
    do_op("fe_rd_7e", BASE, 4'h0, 32'h0, 1'b1, 32'h7E);
    do_op("fe_rd_empty", BASE, 4'h0, 32'h0, 1'b1, 32'h8000_0000);
    do_op("fe_clr", STAT, 4'h1, 32'h4, 1'b0, 32'h0);
    do_op("fe_status_clr", STAT, 4'h0, 32'h0, 1'b1, 32'h0);

    // pop and push in the same cycle on a full FIFO
    for (int i = 1; i <= 4; i++) send_m(8'(i * 16), 1'b1);
    do_op("full_status", STAT, 4'h0, 32'h0, 1'b1, 32'h1);
    send(8'h50, 1'b1, 0, 1'b1, r);
    e = model_op(BASE, 4'h0, 32'h0);
    model_push(8'h50);
    chk("pushpop_head", r, e);
    chk("pushpop_head_const", r, 32'h10);
    do_op("pushpop_status", STAT, 4'h0, 32'h0, 1'b1, 32'h1);
    do_op("pushpop_rd1", BASE, 4'h0, 32'h0, 1'b1, 32'h20);
    do_op("pushpop_rd2", BASE, 4'h0, 32'h0, 1'b1, 32'h30);
    do_op("pushpop_rd3", BASE, 4'h0, 32'h0, 1'b1, 32'h40);
    do_op("pushpop_rd4", BASE, 4'h0, 32'h0, 1'b1, 32'h50);
    do_op("pushpop_empty", BASE, 4'h0, 32'h0, 1'b1, 32'h8000_0000);

    // random frames and accesses against the model
    for (int n = 0; n < 16; n++) begin
      logic [7:0] b;
      bit ok;
      int nops;
      b    = 8'($urandom);
      ok   = ($urandom_range(0, 4) != 0);
      send_m(b, ok);
      nops = $urandom_range(0, 3);
      for (int k = 0; k < nops; k++) begin
        case ($urandom_range(0, 4))
          0, 1: do_op("rnd_rd_base", BASE, 4'h0, 32'h0, 1'b0, 32'h0);
          2:    do_op("rnd_rd_stat", STAT, 4'h0, 32'h0, 1'b0, 32'h0);
          3:    do_op("rnd_wr_stat", STAT, 4'($urandom_range(1, 15)), $urandom, 1'b0, 32'h0);
          default: do_op("rnd_rd_other", BASE - 32'd4, 4'h0, 32'h0, 1'b0, 32'h0);
        endcase
      end
    end
    do_op("rnd_final_stat", STAT, 4'h0, 32'h0, 1'b0, 32'h0);

    // reset mid-frame at data bit 4, line still low at release
    send_m(8'h11, 1'b1);
    @(negedge clk); rxd = 1'b0;
    repeat (DIV * 5 + DIV / 2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_reset();
    chk("midrst_irq", {31'h0, rx_irq}, 32'h0);
    repeat (20) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    send_m(8'hC9, 1'b1);
    do_op("midrst_status", STAT, 4'h0, 32'h0, 1'b1, 32'h1);
    do_op("midrst_rd_c9", BASE, 4'h0, 32'h0, 1'b1, 32'hC9);
    do_op("midrst_empty", BASE, 4'h0, 32'h0, 1'b1, 32'h8000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
